// File: rtl/state_stack_pkg.sv
// Shared field layout and helpers for recursion call-state entries.
// Entry packing is {pos, addr, done} with done in bit 0.
package state_stack_pkg;

  localparam int POS_W    = 5;
  localparam int SADDR_W  = 12;
  localparam int DONE_BIT = 0;
  localparam int ENTRY_W  = POS_W + SADDR_W + 1;

  typedef struct packed {
    logic [POS_W-1:0]   pos;
    logic [SADDR_W-1:0] addr;
    logic               done;
  } state_entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [POS_W-1:0]   pos,
    input logic [SADDR_W-1:0] addr,
    input logic               done
  );
    state_entry_t e;
    e.pos  = pos;
    e.addr = addr;
    e.done = done;
    return e;
  endfunction

  function automatic state_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    return state_entry_t'(raw);
  endfunction

  function automatic logic entry_done(input logic [ENTRY_W-1:0] raw);
    return raw[DONE_BIT];
  endfunction

endpackage

// File: rtl/state_stack_mem.sv
// Two-write / two-read storage array for the call-state stack.
// STATE_STACK_BYPASS_EN selects write-first forwarding; default is read-first.
module state_stack_mem
  import state_stack_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              push_we,
  input  logic [ADDR_W-1:0] push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_pop,
  input  logic              ran_we,
  input  logic [ADDR_W-1:0] ran_w_addr,
  input  logic [DATA_W-1:0] ran_w_data,
  input  logic [ADDR_W-1:0] pop_idx,
  input  logic [ADDR_W-1:0] ran_r_addr,
  output logic [DATA_W-1:0] pop_rd_data,
  output logic [DATA_W-1:0] ran_rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef STATE_STACK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  // Push is written last so it wins over a random write to the same index.
  always_ff @(posedge clk) begin
    if (ran_we)
      mem[ran_w_addr[IDX_W-1:0]] <= ran_w_data;
    if (push_we)
      mem[push_idx[IDX_W-1:0]] <= push_data;
  end

  always_comb begin
    pop_rd_data = mem[pop_idx[IDX_W-1:0]];
    ran_rd_data = mem[ran_r_addr[IDX_W-1:0]];
    if (BYPASS) begin
      // A push+pop must still hand back the old top, so only the random write forwards to pop.
      if (ran_we && !push_pop && (ran_w_addr == pop_idx))
        pop_rd_data = ran_w_data;
      if (push_we && (ran_r_addr == push_idx))
        ran_rd_data = push_data;
      else if (ran_we && (ran_r_addr == ran_w_addr))
        ran_rd_data = ran_w_data;
    end
  end

endmodule

// File: rtl/state_stack_file.sv
// Call-state stack with concurrent random port, registered read outputs and error pulses.
// Optional write-first forwarding in the array under STATE_STACK_BYPASS_EN.
module state_stack_file
  import state_stack_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              ran_we,
  input  logic [ADDR_W-1:0] ran_w_addr,
  input  logic [DATA_W-1:0] ran_w_data,
  input  logic              ran_re,
  input  logic [ADDR_W-1:0] ran_r_addr,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              ran_valid,
  output logic [DATA_W-1:0] ran_r_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_range
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_I   = ADDR_W'(1);

  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              is_empty;
  logic              is_full;
  logic              do_pop;
  logic              do_push;
  logic              push_pop;
  logic              ran_w_ok;
  logic              ran_r_ok;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] push_idx;
  logic [DATA_W-1:0] pop_rd_data;
  logic [DATA_W-1:0] ran_rd_data;

  // All decisions use the occupancy sampled at the start of the cycle.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == DEPTH_C);
    do_pop   = pop && !is_empty;
    do_push  = push && (!is_full || do_pop);
    push_pop = do_push && do_pop;
    top_idx  = count_q[ADDR_W-1:0] - ONE_I;
    push_idx = do_pop ? top_idx : count_q[ADDR_W-1:0];
    ran_w_ok = ({1'b0, ran_w_addr} < count_q);
    ran_r_ok = ({1'b0, ran_r_addr} < count_q);
    count_nxt = count_q;
    if (do_push && !do_pop)
      count_nxt = count_q + ONE_C;
    else if (do_pop && !do_push)
      count_nxt = count_q - ONE_C;
  end

  state_stack_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk         (clk),
    .push_we     (do_push),
    .push_idx    (push_idx),
    .push_data   (push_data),
    .push_pop    (push_pop),
    .ran_we      (ran_we && ran_w_ok),
    .ran_w_addr  (ran_w_addr),
    .ran_w_data  (ran_w_data),
    .pop_idx     (top_idx),
    .ran_r_addr  (ran_r_addr),
    .pop_rd_data (pop_rd_data),
    .ran_rd_data (ran_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      pop_valid  <= 1'b0;
      pop_data   <= '0;
      pop_addr   <= '0;
      ran_valid  <= 1'b0;
      ran_r_data <= '0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      count_q   <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == DEPTH_C);
      pop_valid <= do_pop;
      ran_valid <= ran_re;
      err_ovf   <= push && is_full && !do_pop;
      err_unf   <= pop && is_empty;
      err_range <= (ran_we && !ran_w_ok) || (ran_re && !ran_r_ok);
      if (do_pop) begin
        pop_data <= pop_rd_data;
        pop_addr <= top_idx;
      end
      if (ran_re)
        ran_r_data <= ran_r_ok ? ran_rd_data : '0;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_state_stack_file.sv
// Bench for state_stack_file: directed scenarios plus randomized traffic against a queue model.
// Follows STATE_STACK_BYPASS_EN when predicting same-cycle read/write results.
module tb_state_stack_file;
  import state_stack_pkg::*;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

`ifdef STATE_STACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              ran_we;
  logic [ADDR_W-1:0] ran_w_addr;
  logic [DATA_W-1:0] ran_w_data;
  logic              ran_re;
  logic [ADDR_W-1:0] ran_r_addr;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] pop_addr;
  logic              ran_valid;
  logic [DATA_W-1:0] ran_r_data;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              err_ovf;
  logic              err_unf;
  logic              err_range;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stack as a queue, index 0 at the bottom.
  logic [DATA_W-1:0] stk[$];
  logic              exp_pop_valid;
  logic [DATA_W-1:0] exp_pop_data;
  logic [ADDR_W-1:0] exp_pop_addr;
  logic              exp_ran_valid;
  logic [DATA_W-1:0] exp_ran;
  logic              exp_ovf;
  logic              exp_unf;
  logic              exp_rng;

  state_stack_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .ran_we(ran_we), .ran_w_addr(ran_w_addr), .ran_w_data(ran_w_data),
    .ran_re(ran_re), .ran_r_addr(ran_r_addr), .pop_valid(pop_valid),
    .pop_data(pop_data), .pop_addr(pop_addr), .ran_valid(ran_valid),
    .ran_r_data(ran_r_data), .count(count), .empty(empty), .full(full),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    stk.delete();
    exp_pop_valid = 1'b0;
    exp_pop_data  = '0;
    exp_pop_addr  = '0;
    exp_ran_valid = 1'b0;
    exp_ran       = '0;
    exp_ovf       = 1'b0;
    exp_unf       = 1'b0;
    exp_rng       = 1'b0;
  endtask

  // Drive one cycle of requests, predict the registered results, return at posedge+1.
  task automatic cycle(input logic p, input logic [DATA_W-1:0] pd, input logic po,
                       input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic re, input logic [ADDR_W-1:0] ra);
    int n;
    n = stk.size();
    push = p; push_data = pd; pop = po;
    ran_we = we; ran_w_addr = wa; ran_w_data = wd;
    ran_re = re; ran_r_addr = ra;

    exp_pop_valid = po && (n > 0);
    if (exp_pop_valid) begin
      exp_pop_addr = ADDR_W'(n - 1);
      exp_pop_data = stk[n-1];
      if (BYP && !p && we && (int'(wa) == n - 1))
        exp_pop_data = wd;
    end
    exp_ran_valid = re;
    if (re) begin
      if (int'(ra) < n) begin
        exp_ran = stk[ra];
        if (BYP) begin
          if (p && po && (int'(ra) == n - 1))
            exp_ran = pd;
          else if (we && (wa == ra))
            exp_ran = wd;
        end
      end else begin
        exp_ran = '0;
      end
    end
    exp_ovf = p && (n == DEPTH) && !po;
    exp_unf = po && (n == 0);
    exp_rng = (we && int'(wa) >= n) || (re && int'(ra) >= n);

    if (we && int'(wa) < n)
      stk[wa] = wd;
    if (po && n > 0) begin
      if (p) stk[n-1] = pd;
      else void'(stk.pop_back());
    end else if (p && n < DEPTH) begin
      stk.push_back(pd);
    end

    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; ran_we = 1'b0; ran_re = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push = 1'b0; push_data = '0; pop = 1'b0;
    ran_we = 1'b0; ran_w_addr = '0; ran_w_data = '0;
    ran_re = 1'b0; ran_r_addr = '0;
    model_reset();
    #12;
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
    end
    n_tests++;
    if ({pop_valid, ran_valid, err_ovf, err_unf, err_range} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, want 00000", {pop_valid, ran_valid, err_ovf, err_unf, err_range});
    end
    n_tests++;
    if (pop_data !== '0 || pop_addr !== '0 || ran_r_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got pop_data=%h pop_addr=%h ran=%h, want 0", pop_data, pop_addr, ran_r_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lifo();
    logic [DATA_W-1:0] want_d [3];
    want_d[0] = 18'h00003; want_d[1] = 18'h00002; want_d[2] = 18'h00001;
    for (int i = 1; i <= 3; i++)
      cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL lifo_count: got %0d, want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
      n_tests++;
      if (pop_valid !== 1'b1 || pop_data !== want_d[i] || pop_addr !== ADDR_W'(2 - i)) begin
        n_fail++;
        $display("FAIL lifo_pop%0d: got v=%b d=%h a=%0d, want v=1 d=%h a=%0d",
                 i, pop_valid, pop_data, pop_addr, want_d[i], 2 - i);
      end
    end
    n_tests++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL lifo_empty: got empty=%b count=%0d, want 1/0", empty, count);
    end
    idle();
    n_tests++;
    if (pop_valid !== 1'b0 || pop_data !== 18'h00001) begin
      n_fail++;
      $display("FAIL lifo_hold: got v=%b d=%h, want v=0 d=00001", pop_valid, pop_data);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (err_unf !== 1'b1 || pop_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL unf_pulse: got err_unf=%b pop_valid=%b count=%0d, want 1/0/0", err_unf, pop_valid, count);
    end
    idle();
    n_tests++;
    if (err_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_single: got err_unf=%b, want 0", err_unf);
    end
  endtask

  task automatic test_push_pop_empty();
    cycle(1'b1, 18'h0002A, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (count !== 5'd1 || err_unf !== 1'b1 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_empty: got count=%0d err_unf=%b pop_valid=%b, want 1/1/0", count, err_unf, pop_valid);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (pop_data !== 18'h0002A || count !== 5'd0) begin
      n_fail++;
      $display("FAIL pp_empty_pop: got d=%h count=%0d, want 0002a/0", pop_data, count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, DATA_W'(16 + i), 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (full !== 1'b1 || count !== 5'd4) begin
      n_fail++;
      $display("FAIL full_flag: got full=%b count=%0d, want 1/4", full, count);
    end
    cycle(1'b1, 18'h00099, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (err_ovf !== 1'b1 || count !== 5'd4 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf: got err_ovf=%b count=%0d full=%b, want 1/4/1", err_ovf, count, full);
    end
    cycle(1'b1, 18'h00055, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (pop_valid !== 1'b1 || pop_data !== 18'h00013 || pop_addr !== 4'd3 || count !== 5'd4 || err_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got v=%b d=%h a=%0d count=%0d ovf=%b, want 1/00013/3/4/0",
               pop_valid, pop_data, pop_addr, count, err_ovf);
    end
  endtask

  task automatic test_random_read();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    n_tests++;
    if (pop_data !== 18'h00055 || count !== 5'd3) begin
      n_fail++;
      $display("FAIL rr_setup: got d=%h count=%0d, want 00055/3", pop_data, count);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd1);
    n_tests++;
    if (ran_valid !== 1'b1 || ran_r_data !== 18'h00011 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_in_range: got v=%b d=%h err=%b, want 1/00011/0", ran_valid, ran_r_data, err_range);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    n_tests++;
    if (ran_valid !== 1'b1 || ran_r_data !== 18'h0 || err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_out_range: got v=%b d=%h err=%b, want 1/00000/1", ran_valid, ran_r_data, err_range);
    end
  endtask

  task automatic test_write_during_pop();
    logic [DATA_W-1:0] want;
    want = BYP ? 18'h3FFFF : 18'h00012;
    cycle(1'b0, '0, 1'b1, 1'b1, 4'd2, 18'h3FFFF, 1'b0, '0);
    n_tests++;
    if (pop_data !== want || count !== 5'd2 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pop: got d=%h count=%0d err=%b, want %h/2/0", pop_data, count, err_range, want);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 4'd2, 18'h12345, 1'b1, 4'd1);
    n_tests++;
    if (ran_r_data !== 18'h00011 || err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_drop: got d=%h err=%b, want 00011/1", ran_r_data, err_range);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 18'h00077, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 4'd0);
    n_tests++;
    if (pop_data !== 18'h00077 || ran_r_data !== 18'h00010) begin
      n_fail++;
      $display("FAIL mid_setup: got pop=%h ran=%h, want 00077/00010", pop_data, ran_r_data);
    end
    pop = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (pop_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || pop_data !== '0 || ran_r_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b count=%0d empty=%b pop=%h ran=%h, want 0/0/1/0/0",
               pop_valid, count, empty, pop_data, ran_r_data);
    end
    @(negedge clk);
    pop = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (pop_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_after: got v=%b count=%0d, want 0/0", pop_valid, count);
    end
  endtask

  task automatic test_random();
    logic              p, po, we, re;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] pd, wd;
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 40);
      we = ($urandom_range(0, 99) < 40);
      re = ($urandom_range(0, 99) < 50);
      wa = ADDR_W'($urandom_range(0, 5));
      ra = ADDR_W'($urandom_range(0, 5));
      pd = pack_entry(POS_W'($urandom), SADDR_W'($urandom), 1'($urandom));
      wd = DATA_W'($urandom);
      cycle(p, pd, po, we, wa, wd, re, ra);
      n_tests++;
      if (pop_valid !== exp_pop_valid || pop_data !== exp_pop_data || pop_addr !== exp_pop_addr) begin
        n_fail++;
        $display("FAIL rnd_pop[%0d]: got v=%b d=%h a=%0d, want v=%b d=%h a=%0d",
                 i, pop_valid, pop_data, pop_addr, exp_pop_valid, exp_pop_data, exp_pop_addr);
      end
      n_tests++;
      if (ran_valid !== exp_ran_valid || ran_r_data !== exp_ran) begin
        n_fail++;
        $display("FAIL rnd_ran[%0d]: got v=%b d=%h, want v=%b d=%h", i, ran_valid, ran_r_data, exp_ran_valid, exp_ran);
      end
      n_tests++;
      if (count !== (ADDR_W + 1)'(stk.size()) || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_count[%0d]: got count=%0d empty=%b full=%b, want count=%0d",
                 i, count, empty, full, stk.size());
      end
      n_tests++;
      if ({err_ovf, err_unf, err_range} !== {exp_ovf, exp_unf, exp_rng}) begin
        n_fail++;
        $display("FAIL rnd_err[%0d]: got ovf/unf/rng=%b, want %b", i, {err_ovf, err_unf, err_range},
                 {exp_ovf, exp_unf, exp_rng});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_underflow();
    test_push_pop_empty();
    test_full();
    test_random_read();
    test_write_during_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/state_stack_file.md
# state_stack_file

Parametrised call-state store for the recursion engine: one entry per active InexRecur call, holding the 5-bit call position, 12-bit parameter address and done flag. It adds stack semantics (push/pop with occupancy), an independent random read/write port usable in the same cycle as push/pop, registered read outputs with valid strobes, and error reporting. It sits between the accelerator FSM and the parameter register file. It replaces the single-output state file, whose output mux made sequential and random reads mutually exclusive.

## Interface
- DATA_W, 18: entry width, packed as {pos[4:0], addr[11:0], done}; done is bit 0.
- ADDR_W, 12: index width.
- DEPTH, 4096: number of entries; must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- push  in  1  write push_data at index count, then count+1.
- push_data  in  DATA_W  entry to push.
- pop  in  1  read the entry at count-1, then count-1.
- ran_we  in  1  random write enable.
- ran_w_addr  in  ADDR_W  random write index.
- ran_w_data  in  DATA_W  random write data.
- ran_re  in  1  random read enable.
- ran_r_addr  in  ADDR_W  random read index.
- pop_valid  out  1  pop_data/pop_addr valid this cycle.
- pop_data  out  DATA_W  popped entry.
- pop_addr  out  ADDR_W  index the popped entry came from.
- ran_valid  out  1  ran_r_data valid this cycle.
- ran_r_data  out  DATA_W  random read entry.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- empty, full  out  1  count==0 / count==DEPTH.
- err_ovf, err_unf, err_range  out  1  one-cycle error pulses.

## Operation
- Valid entries are indices 0..count-1. Random accesses to index >= count are out of range.
- Push while not full: writes push_data at index count and increments count.
- Push while full, without pop: ignored; err_ovf pulses.
- Pop while not empty: returns the entry at count-1 and decrements count.
- Pop while empty: ignored; pop_valid stays 0; err_unf pulses.
- Push+pop in the same cycle while not empty: pop returns the old top entry, push_data overwrites index count-1, and count is unchanged. Allowed when full.
- Push+pop in the same cycle while empty: treated as a push only; err_unf pulses.
- Random write, in range: updates the entry.
- Random write, out of range: dropped; err_range pulses.
- Random read, out of range: ran_valid=1, ran_r_data=0, err_range pulses.
- Range checks always use count sampled at the start of the cycle.
- Random port and push/pop are fully concurrent.
- Push index and random-write index cannot collide, because index count is never in range.
- Random write and push+pop to the same index (count-1): the push wins.
- The storage array is not reset; only pointers and outputs are.

## Timing
- Pop and random read latency is 1 cycle. Data is registered, so it is valid the cycle after the request, qualified by pop_valid / ran_valid.
- Valid strobes are single-cycle pulses. Outputs hold their last value while the strobe is low.
- count, empty and full update on the same edge as the push/pop.
- Back-to-back pops each cycle return successive entries, count-1, count-2, …
- Reset values: count=0, empty=1, full=0; all valid strobes, error pulses and data outputs 0.
- Reset asserted mid-operation: everything clears asynchronously, and any pending read result is discarded (no valid pulse).

## Configuration
- STATE_STACK_BYPASS_EN defined: write-first forwarding.
  - A read whose index matches a same-cycle write returns the written data.
  - Push+pop returns the old top entry, as in Operation.
  - Random read of count-1 during push+pop returns push_data.
  - Random read matching ran_w_addr returns ran_w_data.
- STATE_STACK_BYPASS_EN undefined: read-first. Every read returns the array contents from before the edge.

## Structure
- Package state_stack_pkg holds:
  - the field widths POS_W=5, SADDR_W=12 and DONE_BIT=0;
  - the packed entry struct;
  - pack/unpack functions.
- Sub-module state_stack_mem holds the 2-write/2-read register array:
  - write ports: push and random;
  - read ports: pop and random;
  - bypass muxing under the macro.
- The top level holds count, the range checks, the error logic and the output registers.

## Test plan
- Reset, then push 0x00001, 0x00002, 0x00003; pop 3 times → pop_data 0x00003, 0x00002, 0x00001 on consecutive cycles with pop_addr 2,1,0, then empty=1.
- Pop when empty → err_unf=1 for one cycle, pop_valid=0, count stays 0.
- Fill with DEPTH=4: four pushes → full=1. A fifth push → err_ovf=1 and count stays 4. Then push+pop → old top returned, count=4.
- With count=3: random read index 1 → ran_valid and correct data after 1 cycle. Random read index 3 → ran_r_data=0 and err_range=1.
- Random write 0x3FFFF to index 2 in the same cycle as a pop with count=3:
  - with STATE_STACK_BYPASS_EN → pop_data=0x3FFFF;
  - without it → the old value.
- Assert rst_n low for one cycle after a pop request, before the result is returned → no pop_valid pulse, count=0, all outputs 0.
